// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table response capture block.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } tt_state_t;

  function automatic int entries(input int nIn);
    return 1 << nIn;
  endfunction

endpackage

// File: rtl/tt_timeout_timer.sv
// Stall counter: counts enabled cycles since the last clear and flags the
// cycle whose increment would reach TIMEOUT (never flags when TIMEOUT is 0).
module tt_timeout_timer #(
  parameter int TIMEOUT = 255,
  localparam int W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [W-1:0] LAST = (TIMEOUT == 0) ? '0 : W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  // Saturates at LAST so a disabled timeout never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (TIMEOUT != 0) && en && !clr && (cnt == LAST);

endmodule

// File: rtl/tt_response_capture.sv
// Samples Y for each applied input code, builds the observed truth table and
// compares it against a latched expected minterm vector.
module tt_response_capture
  import tt_pkg::*;
#(
  parameter int N_IN    = 3,
  parameter int TIMEOUT = 255,
  localparam int ENTRIES = entries(N_IN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ENTRIES-1:0] expected,
  input  logic               smp_valid,
  input  logic [N_IN-1:0]    smp_code,
  input  logic               smp_y,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               timeout,
  output logic               dup,
  output logic [ENTRIES-1:0] seen,
  output logic [ENTRIES-1:0] captured,
  output logic [ENTRIES-1:0] mismatch
);

  tt_state_t          state;
  logic [ENTRIES-1:0] expQ;
  logic [ENTRIES-1:0] seenNext;
  logic [ENTRIES-1:0] capNext;
  logic [ENTRIES-1:0] misNext;
  logic               dupNext;
  logic               tmrClr;
  logic               tmrExpire;

  // Any valid sample restarts the stall count; outside CAPTURE it is held at 0.
  assign tmrClr = start || (state != CAPTURE) || smp_valid;

  tt_timeout_timer #(
    .TIMEOUT(TIMEOUT)
  ) uTimer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmrClr),
    .en    (state == CAPTURE),
    .expire(tmrExpire)
  );

  // Table update for the sample on the current cycle; first Y for a code wins.
  always_comb begin
    seenNext = seen;
    capNext  = captured;
    dupNext  = dup;
    if (smp_valid) begin
      if (!seen[smp_code]) begin
        seenNext[smp_code] = 1'b1;
        capNext[smp_code]  = smp_y;
      end else if (captured[smp_code] != smp_y) begin
        dupNext = 1'b1;
      end
    end
    misNext = (capNext ^ expQ) & seenNext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      expQ     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      timeout  <= 1'b0;
      dup      <= 1'b0;
      seen     <= '0;
      captured <= '0;
      mismatch <= '0;
    end else if (start) begin
      state    <= CAPTURE;
      expQ     <= expected;
      busy     <= 1'b1;
      done     <= 1'b0;
      pass     <= 1'b0;
      timeout  <= 1'b0;
      dup      <= 1'b0;
      seen     <= '0;
      captured <= '0;
      mismatch <= '0;
    end else if (state == CAPTURE) begin
      seen     <= seenNext;
      captured <= capNext;
      mismatch <= misNext;
      dup      <= dupNext;
      // Completing the table takes priority over a stall expiring.
      if (&seenNext) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        pass  <= (misNext == '0) && !dupNext;
      end else if (tmrExpire) begin
        state   <= DONE;
        busy    <= 1'b0;
        done    <= 1'b1;
        timeout <= 1'b1;
        pass    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tt_response_capture.sv
// Directed and randomized checks of tt_response_capture against a
// table-level reference model (per-code arrays plus an idle-cycle count).
module tb_tt_response_capture;

  localparam int N_IN = 3;
  localparam int ENT  = 8;
  localparam int TO   = 4;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [ENT-1:0] expected;
  logic           smp_valid;
  logic [N_IN-1:0] smp_code;
  logic           smp_y;
  logic           busy, done, pass, timeout, dup;
  logic [ENT-1:0] seen, captured, mismatch;

  int nChecks = 0;
  int nFail   = 0;

  // Reference model state
  bit mSeen[ENT];
  bit mCap[ENT];
  bit mExp[ENT];
  bit mBusy, mDone, mPass, mTo, mDup;
  int mIdle;

  tt_response_capture #(
    .N_IN   (N_IN),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .expected (expected),
    .smp_valid(smp_valid),
    .smp_code (smp_code),
    .smp_y    (smp_y),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .timeout  (timeout),
    .dup      (dup),
    .seen     (seen),
    .captured (captured),
    .mismatch (mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < ENT; i++) begin
      mSeen[i] = 0;
      mCap[i]  = 0;
      mExp[i]  = 0;
    end
    mBusy = 0; mDone = 0; mPass = 0; mTo = 0; mDup = 0; mIdle = 0;
  endtask

  task automatic checkAll(input string tag);
    logic [ENT-1:0] s, c, m;
    for (int i = 0; i < ENT; i++) begin
      s[i] = mSeen[i];
      c[i] = mCap[i];
      m[i] = mSeen[i] && (mCap[i] != mExp[i]);
    end
    chk({tag, ".busy"}, 32'(busy), 32'(mBusy));
    chk({tag, ".done"}, 32'(done), 32'(mDone));
    chk({tag, ".pass"}, 32'(pass), 32'(mPass));
    chk({tag, ".timeout"}, 32'(timeout), 32'(mTo));
    chk({tag, ".dup"}, 32'(dup), 32'(mDup));
    chk({tag, ".seen"}, 32'(seen), 32'(s));
    chk({tag, ".captured"}, 32'(captured), 32'(c));
    chk({tag, ".mismatch"}, 32'(mismatch), 32'(m));
  endtask

  // One clock: drive inputs, advance the model on the edge, check after it.
  task automatic step(input string tag, input logic st, input logic v,
                      input int code, input logic y);
    bit allSeen, anyMis;
    start     = st;
    smp_valid = v;
    smp_code  = N_IN'(code);
    smp_y     = y;
    @(posedge clk);
    if (st) begin
      modelReset();
      for (int i = 0; i < ENT; i++) mExp[i] = expected[i];
      mBusy = 1;
    end else if (mBusy) begin
      if (v) begin
        mIdle = 0;
        if (!mSeen[code]) begin
          mSeen[code] = 1;
          mCap[code]  = y;
        end else if (mCap[code] != y) begin
          mDup = 1;
        end
      end else begin
        mIdle++;
      end
      allSeen = 1;
      anyMis  = 0;
      for (int i = 0; i < ENT; i++) begin
        if (!mSeen[i]) allSeen = 0;
        if (mSeen[i] && mCap[i] != mExp[i]) anyMis = 1;
      end
      if (allSeen) begin
        mBusy = 0; mDone = 1; mPass = !anyMis && !mDup;
      end else if (TO != 0 && mIdle == TO) begin
        mBusy = 0; mDone = 1; mTo = 1; mPass = 0;
      end
    end
    #1;
    checkAll(tag);
    start     = 1'b0;
    smp_valid = 1'b0;
  endtask

  initial begin
    logic [ENT-1:0] ex;
    int order[ENT];
    int budget;
    start = 0; smp_valid = 0; smp_code = 0; smp_y = 0; expected = 0;
    rst_n = 1'b1;
    modelReset();
    #1 rst_n = 1'b0;
    #1 checkAll("reset");
    #10 rst_n = 1'b1;

    // Majority function, full in-order sweep
    ex = 8'hE8;
    expected = ex;
    step("t1.start", 1, 0, 0, 0);
    for (int c = 0; c < ENT; c++) step("t1.smp", 0, 1, c, ex[c]);
    chk("t1.done", 32'(done), 32'd1);
    chk("t1.pass", 32'(pass), 32'd1);
    chk("t1.captured", 32'(captured), 32'hE8);
    chk("t1.mismatch", 32'(mismatch), 32'h0);

    // Wrong Y on code 5
    step("t2.start", 1, 0, 0, 0);
    for (int c = 0; c < ENT; c++) step("t2.smp", 0, 1, c, (c == 5) ? 1'b0 : ex[c]);
    chk("t2.pass", 32'(pass), 32'd0);
    chk("t2.mismatch", 32'(mismatch), 32'h20);
    chk("t2.captured", 32'(captured), 32'hC8);

    // Conflicting repeat of code 3
    step("t3.start", 1, 0, 0, 0);
    step("t3.c3a", 0, 1, 3, 1);
    step("t3.c3b", 0, 1, 3, 0);
    for (int c = 0; c < ENT; c++) if (c != 3) step("t3.smp", 0, 1, c, ex[c]);
    chk("t3.dup", 32'(dup), 32'd1);
    chk("t3.cap3", 32'(captured[3]), 32'd1);
    chk("t3.pass", 32'(pass), 32'd0);

    // Stall after five codes
    step("t4.start", 1, 0, 0, 0);
    for (int c = 0; c < 5; c++) step("t4.smp", 0, 1, c, ex[c]);
    for (int k = 0; k < TO - 1; k++) step("t4.idle", 0, 0, 0, 0);
    chk("t4.notyet", 32'(done), 32'd0);
    step("t4.expire", 0, 0, 0, 0);
    chk("t4.done", 32'(done), 32'd1);
    chk("t4.timeout", 32'(timeout), 32'd1);
    chk("t4.seen", 32'(seen), 32'h1F);
    chk("t4.pass", 32'(pass), 32'd0);

    // Reverse order with gaps, then samples in DONE must be ignored
    step("t5.start", 1, 0, 0, 0);
    for (int c = ENT - 1; c >= 0; c--) begin
      step("t5.smp", 0, 1, c, ex[c]);
      if (c != 0) begin
        step("t5.gap", 0, 0, 0, 0);
        step("t5.gap", 0, 0, 0, 0);
      end
    end
    chk("t5.pass", 32'(pass), 32'd1);
    for (int k = 0; k < 3; k++) step("t5.inDone", 0, 1, $urandom_range(0, ENT - 1), $urandom_range(0, 1));
    chk("t5.seenHeld", 32'(seen), 32'hFF);
    chk("t5.capHeld", 32'(captured), 32'hE8);
    chk("t5.passHeld", 32'(pass), 32'd1);
    chk("t5.doneHeld", 32'(done), 32'd1);

    // Randomized captures: random tables, order, errors, repeats and gaps
    for (int r = 0; r < 25; r++) begin
      expected = ENT'($urandom);
      step("rnd.start", 1, 0, 0, 0);
      budget = 0;
      while (!mDone && budget < 80) begin
        int c;
        logic y;
        c = $urandom_range(0, ENT - 1);
        y = expected[c];
        if ($urandom_range(0, 15) == 0) y = ~y;
        if ($urandom_range(0, 9) < 7) step("rnd.smp", 0, 1, c, y);
        else step("rnd.idle", 0, 0, 0, 0);
        budget++;
      end
      chk("rnd.finished", 32'(done), 32'd1);
    end

    // start together with a sample mid-capture, then async reset mid-capture
    expected = ex;
    step("t6.start", 1, 0, 0, 0);
    for (int c = 0; c < 3; c++) step("t6.smp", 0, 1, c, ex[c]);
    step("t6.restart", 1, 1, 4, 1);
    chk("t6.seen", 32'(seen), 32'h0);
    chk("t6.busy", 32'(busy), 32'd1);
    step("t6.smp", 0, 1, 6, 1);
    step("t6.smp", 0, 1, 7, 1);
    #2 rst_n = 1'b0;
    modelReset();
    #1 checkAll("t6.asyncRst");
    #1 rst_n = 1'b1;

    // Block is usable again after the reset
    step("t7.start", 1, 0, 0, 0);
    for (int c = 0; c < ENT; c++) step("t7.smp", 0, 1, c, ex[c]);
    chk("t7.pass", 32'(pass), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
